// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the boot sequencer: FSM state encoding, state width,
// byte-lane geometry of a 32-bit instruction word and small state-decode
// helpers used by boot_sequencer.
// -----------------------------------------------------------------------------
package boot_pkg;

  localparam int STATE_W = 3;

  // A 32-bit instruction word is built from four little-endian byte lanes.
  localparam int         LANE_W    = 8;
  localparam int         LANES     = 4;
  localparam int         WORD_W    = LANE_W * LANES;
  localparam logic [1:0] LAST_LANE = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_HDR0    = 3'd1,
    S_HDR1    = 3'd2,
    S_LOAD    = 3'd3,
    S_CKSUM   = 3'd4,
    S_RELEASE = 3'd5,
    S_RUN     = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  // States in which a byte from the host link may be consumed.
  function automatic logic f_accepting(input state_t s);
    return (s == S_HDR0) || (s == S_HDR1) || (s == S_LOAD) || (s == S_CKSUM);
  endfunction

  // States that form a load in progress (start is ignored here).
  function automatic logic f_busy(input state_t s);
    return f_accepting(s) || (s == S_RELEASE);
  endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// -----------------------------------------------------------------------------
// boot_word_assembler
// Collects little-endian bytes into 32-bit words. Byte j of a word lands in
// bits [8*j+:8]. When the fourth byte is taken, the completed word is
// presented for exactly one cycle on the following cycle.
//
// Ports:
//   clk, resetb   clock, asynchronous active-low reset
//   i_clear       restart at byte 0 (asserted on entry to header phase)
//   i_valid       a payload byte is accepted this cycle
//   i_byte        the payload byte
//   o_last_lane   the next accepted byte completes a word (byte index == 3)
//   o_word_valid  one-cycle pulse carrying a completed word
//   o_word        completed word, held until the next word completes
// -----------------------------------------------------------------------------
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              resetb,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [LANE_W-1:0] i_byte,
  output logic              o_last_lane,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  logic [1:0]               r_idx;
  logic [WORD_W-LANE_W-1:0] r_lanes_p0;
  logic                     r_vld_p1;
  logic [WORD_W-1:0]        r_word_p1;

  assign o_last_lane  = (r_idx == LAST_LANE);
  assign o_word_valid = r_vld_p1;
  assign o_word       = r_word_p1;

  // p0: lanes 0..2 are parked; lane 3 goes straight into the p1 word register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_idx      <= '0;
      r_lanes_p0 <= '0;
      r_vld_p1   <= 1'b0;
      r_word_p1  <= '0;
    end else begin
      r_vld_p1 <= 1'b0;
      if (i_clear) begin
        r_idx <= '0;
      end else if (i_valid) begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd0:    r_lanes_p0[LANE_W-1:0]          <= i_byte;
          2'd1:    r_lanes_p0[2*LANE_W-1:LANE_W]   <= i_byte;
          2'd2:    r_lanes_p0[3*LANE_W-1:2*LANE_W] <= i_byte;
          default: begin
            // p1: completed word, valid for one cycle
            r_vld_p1  <= 1'b1;
            r_word_p1 <= {i_byte, r_lanes_p0};
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// -----------------------------------------------------------------------------
// boot_sequencer
// Boot controller for the RV32I core. Holds the core in reset, receives a
// program image over a byte link (2-byte little-endian word count followed by
// 4*N little-endian payload bytes), writes each word into instruction memory
// and releases core reset RELEASE_CYCLES cycles after a successful load.
//
// Optional feature (macro BOOT_CHECKSUM_EN): one trailing checksum byte that
// must equal the XOR of all payload bytes; a mismatch ends in ERROR.
//
// Ports:
//   clk, resetb   clock, asynchronous active-low reset
//   start         one-cycle pulse to begin a (re)load (ignored while busy)
//   rx_valid      byte available on rx_data
//   rx_data       byte value
//   rx_ready      sequencer takes a byte this cycle when rx_valid is high
//   im_we         instruction memory write strobe (one cycle per word)
//   im_waddr      word address of the write
//   im_wdata      write data
//   core_resetb   active-low reset to core and mmu
//   busy          load in progress
//   done          image loaded, core running
//   error         load failed (bad count, timeout, checksum); core in reset
// -----------------------------------------------------------------------------
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int IM_WORDS       = 1024,
  parameter int ADDR_W         = 10,
  parameter int RELEASE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              core_resetb,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [REL_W-1:0] REL_LAST  = REL_W'(RELEASE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(IM_WORDS);

  state_t             r_state;
  state_t             w_state_nx;
  logic [7:0]         r_cnt_lo;
  logic [15:0]        r_count;
  logic [15:0]        r_widx;
  logic [ADDR_W-1:0]  r_waddr;
  logic [REL_W-1:0]   r_rel;
  logic [TO_W-1:0]    r_idle;
  logic               r_core_resetb;

  logic               w_accept;
  logic               w_load_byte;
  logic               w_last_lane;
  logic               w_word_done;
  logic               w_last_word;
  logic               w_timeout;
  logic               w_clear;
  logic               w_hdr_bad;
  logic [15:0]        w_hdr_count;
  logic               w_asm_vld;
  logic [31:0]        w_asm_word;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]         r_xor;
`endif

  assign rx_ready    = f_accepting(r_state);
  assign w_accept    = rx_valid & rx_ready;
  assign w_load_byte = w_accept && (r_state == S_LOAD);
  assign w_word_done = w_load_byte && w_last_lane;
  // r_count is at least 1 whenever LOAD is active, so count-1 cannot wrap.
  assign w_last_word = (r_widx == (r_count - 16'd1));
  assign w_hdr_count = {rx_data, r_cnt_lo};
  assign w_hdr_bad   = (w_hdr_count == 16'd0) || ({1'b0, w_hdr_count} > MAX_WORDS);
  // r_idle counts consecutive cycles without a byte in an accepting state;
  // the TIMEOUT_CYCLES-th such cycle aborts the load.
  assign w_timeout   = !w_accept && (r_idle == TO_LAST);
  // Every path into HDR0 restarts word assembly and the checksum.
  assign w_clear     = (w_state_nx == S_HDR0) && (r_state != S_HDR0);

  boot_word_assembler u_asm (
    .clk          (clk),
    .resetb       (resetb),
    .i_clear      (w_clear),
    .i_valid      (w_load_byte),
    .i_byte       (rx_data),
    .o_last_lane  (w_last_lane),
    .o_word_valid (w_asm_vld),
    .o_word       (w_asm_word)
  );

  assign im_we       = w_asm_vld;
  assign im_wdata    = w_asm_word;
  assign im_waddr    = r_waddr;
  assign core_resetb = r_core_resetb;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    busy       = f_busy(r_state);
    done       = (r_state == S_RUN);
    error      = (r_state == S_ERROR);
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nx = S_HDR0;
      end
      S_HDR0: begin
        if (w_accept)       w_state_nx = S_HDR1;
        else if (w_timeout) w_state_nx = S_ERROR;
      end
      S_HDR1: begin
        if (w_accept)       w_state_nx = w_hdr_bad ? S_ERROR : S_LOAD;
        else if (w_timeout) w_state_nx = S_ERROR;
      end
      S_LOAD: begin
        if (w_word_done && w_last_word) begin
`ifdef BOOT_CHECKSUM_EN
          w_state_nx = S_CKSUM;
`else
          w_state_nx = S_RELEASE;
`endif
        end else if (w_timeout) begin
          w_state_nx = S_ERROR;
        end
      end
      S_CKSUM: begin
`ifdef BOOT_CHECKSUM_EN
        if (w_accept)       w_state_nx = (rx_data == r_xor) ? S_RELEASE : S_ERROR;
        else if (w_timeout) w_state_nx = S_ERROR;
`else
        w_state_nx = S_ERROR;
`endif
      end
      S_RELEASE: begin
        if (r_rel == REL_LAST) w_state_nx = S_RUN;
      end
      S_RUN, S_ERROR: begin
        if (start) w_state_nx = S_HDR0;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_cnt_lo      <= '0;
      r_count       <= '0;
      r_widx        <= '0;
      r_waddr       <= '0;
      r_rel         <= '0;
      r_idle        <= '0;
      r_core_resetb <= 1'b0;
    end else begin
      // Core reset follows the FSM: released on the edge into RUN, reasserted
      // on the same edge that a reload leaves RUN.
      r_core_resetb <= (w_state_nx == S_RUN);
      if ((r_state == S_HDR0) && w_accept) begin
        r_cnt_lo <= rx_data;
      end
      if ((r_state == S_HDR1) && w_accept) begin
        r_count <= w_hdr_count;
        r_widx  <= '0;
      end
      // The address is latched with the fourth byte so it lines up with the
      // assembler's write pulse one cycle later.
      if (w_word_done) begin
        r_waddr <= r_widx[ADDR_W-1:0];
        r_widx  <= r_widx + 16'd1;
      end
      r_rel  <= (r_state == S_RELEASE) ? r_rel + REL_W'(1) : '0;
      r_idle <= (!rx_ready || w_accept) ? '0 : r_idle + TO_W'(1);
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_xor <= '0;
    end else if (w_clear) begin
      r_xor <= '0;
    end else if (w_load_byte) begin
      r_xor <= r_xor ^ rx_data;
    end
  end
`endif

endmodule
